// File: rtl/osram_unloader.sv
// osram_unloader: drains partial-sum rows from the output SRAM and streams them
// out as out_bw-bit beats on a valid/ready interface.
//   clk, reset      clock, synchronous active-low reset
//   start, rows     begin an unload of rows 0..rows-1 (rows clamped to 2**addr_bw)
//   O_Q/O_A/O_CEN/O_WEN  OSRAM read port (one-cycle read latency, WEN tied high)
//   out_data/out_valid/out_ready/out_last  beat stream, LSB beat of each row first
//   busy, done      unload in progress / one-cycle completion pulse
module osram_unloader #(
    parameter int unsigned COL     = 8,
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned ADDR_BW = 4,
    parameter int unsigned OUT_BW  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BW:0]         rows,
    input  logic [COL*PSUM_BW-1:0]   O_Q,
    output logic [ADDR_BW-1:0]       O_A,
    output logic                     O_CEN,
    output logic                     O_WEN,
    output logic [OUT_BW-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned ROW_W    = COL * PSUM_BW;
    localparam int unsigned BPR      = ROW_W / OUT_BW;
    localparam int unsigned BEAT_W   = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int unsigned CNT_W    = ADDR_BW + 1;
    localparam int unsigned MAX_ROWS = 2 ** ADDR_BW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t                  r_state,   w_state_n;
    logic [CNT_W-1:0]        r_rows,    w_rows_n;
    logic [CNT_W-1:0]        r_rd_ptr,  w_rd_ptr_n;
    logic [CNT_W-1:0]        r_row_cnt, w_row_cnt_n;
    logic [BEAT_W-1:0]       r_beat,    w_beat_n;
    logic                    r_rd_sel,  w_rd_sel_n;
    logic                    r_wr_sel,  w_wr_sel_n;
    logic [1:0]              r_occ,     w_occ_n;
    logic [1:0]              r_full,    w_full_n;
    logic [1:0][ROW_W-1:0]   r_buf,     w_buf_n;
    logic                    r_pend_sel, w_pend_sel_n;
    logic                    r_cap_vld,  w_cap_vld_n;
    logic                    r_cap_sel,  w_cap_sel_n;
    logic                    r_cen;
    logic [ADDR_BW-1:0]      r_addr,    w_addr_n;
    logic [OUT_BW-1:0]       r_out_data, w_out_data_n;
    logic                    r_out_valid, w_out_valid_n;
    logic                    r_out_last,  w_out_last_n;
    logic                    r_busy, r_done;
    logic                    w_issue, w_free, w_hs;
    logic [CNT_W-1:0]        w_rows_clamp;

    assign w_hs         = r_out_valid & out_ready;
    assign w_rows_clamp = (rows > CNT_W'(MAX_ROWS)) ? CNT_W'(MAX_ROWS) : rows;

    // Next-state, read issue, buffer bookkeeping and next stream outputs
    always_comb begin
        w_state_n    = r_state;
        w_rows_n     = r_rows;
        w_rd_ptr_n   = r_rd_ptr;
        w_row_cnt_n  = r_row_cnt;
        w_beat_n     = r_beat;
        w_rd_sel_n   = r_rd_sel;
        w_wr_sel_n   = r_wr_sel;
        w_occ_n      = r_occ;
        w_full_n     = r_full;
        w_buf_n      = r_buf;
        w_pend_sel_n = r_pend_sel;
        w_addr_n     = r_addr;
        w_issue      = 1'b0;
        w_free       = 1'b0;
        // Read pipeline: issue edge -> memory sample edge -> capture edge
        w_cap_vld_n  = ~r_cen;
        w_cap_sel_n  = r_pend_sel;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rows_n    = w_rows_clamp;
                    w_rd_ptr_n  = '0;
                    w_row_cnt_n = '0;
                    w_beat_n    = '0;
                    w_rd_sel_n  = 1'b0;
                    w_wr_sel_n  = 1'b0;
                    w_full_n    = '0;
                    w_occ_n     = '0;
                    if (w_rows_clamp == '0) begin
                        w_state_n = S_FINISH;
                    end else begin
                        // First read goes out on the start edge itself
                        w_state_n    = S_RUN;
                        w_issue      = 1'b1;
                        w_addr_n     = '0;
                        w_pend_sel_n = 1'b0;
                        w_wr_sel_n   = 1'b1;
                        w_rd_ptr_n   = CNT_W'(1);
                        w_occ_n      = 2'd1;
                    end
                end
            end
            S_RUN: begin
                if (w_hs) begin
                    if (r_beat == BEAT_W'(BPR - 1)) begin
                        w_free             = 1'b1;
                        w_full_n[r_rd_sel] = 1'b0;
                        w_rd_sel_n         = ~r_rd_sel;
                        w_beat_n           = '0;
                        w_row_cnt_n        = r_row_cnt + CNT_W'(1);
                    end else begin
                        w_beat_n = r_beat + BEAT_W'(1);
                    end
                    if (r_out_last) begin
                        w_state_n = S_FINISH;
                    end
                end
                // Occupancy counts reserved (in-flight) and full buffers alike
                if ((r_rd_ptr < r_rows) && (r_occ < 2'd2)) begin
                    w_issue      = 1'b1;
                    w_addr_n     = r_rd_ptr[ADDR_BW-1:0];
                    w_pend_sel_n = r_wr_sel;
                    w_wr_sel_n   = ~r_wr_sel;
                    w_rd_ptr_n   = r_rd_ptr + CNT_W'(1);
                end
                // Target buffer was reserved at issue, so it is never full here
                if (r_cap_vld) begin
                    w_buf_n[r_cap_sel]  = O_Q;
                    w_full_n[r_cap_sel] = 1'b1;
                end
                w_occ_n = r_occ + 2'(w_issue) - 2'(w_free);
            end
            S_FINISH: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_out_valid_n = (w_state_n == S_RUN) && w_full_n[w_rd_sel_n];
        w_out_data_n  = w_out_valid_n ?
                        w_buf_n[w_rd_sel_n][OUT_BW*int'(w_beat_n) +: OUT_BW] : '0;
        w_out_last_n  = w_out_valid_n && (w_beat_n == BEAT_W'(BPR - 1)) &&
                        (w_row_cnt_n == w_rows_n - CNT_W'(1));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rows      <= '0;
            r_rd_ptr    <= '0;
            r_row_cnt   <= '0;
            r_beat      <= '0;
            r_rd_sel    <= 1'b0;
            r_wr_sel    <= 1'b0;
            r_occ       <= '0;
            r_full      <= '0;
            r_buf       <= '0;
            r_pend_sel  <= 1'b0;
            r_cap_vld   <= 1'b0;
            r_cap_sel   <= 1'b0;
            r_cen       <= 1'b1;
            r_addr      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_rows      <= w_rows_n;
            r_rd_ptr    <= w_rd_ptr_n;
            r_row_cnt   <= w_row_cnt_n;
            r_beat      <= w_beat_n;
            r_rd_sel    <= w_rd_sel_n;
            r_wr_sel    <= w_wr_sel_n;
            r_occ       <= w_occ_n;
            r_full      <= w_full_n;
            r_buf       <= w_buf_n;
            r_pend_sel  <= w_pend_sel_n;
            r_cap_vld   <= w_cap_vld_n;
            r_cap_sel   <= w_cap_sel_n;
            r_cen       <= ~w_issue;
            r_addr      <= w_addr_n;
            r_out_data  <= w_out_data_n;
            r_out_valid <= w_out_valid_n;
            r_out_last  <= w_out_last_n;
            r_busy      <= (w_state_n == S_RUN);
            r_done      <= (w_state_n == S_FINISH);
        end
    end

    assign O_A       = r_addr;
    assign O_CEN     = r_cen;
    assign O_WEN     = 1'b1;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_osram_unloader.sv
// Testbench for osram_unloader: OSRAM memory model, stream monitor and
// scenario tasks compared against a row/beat reference queue.
module tb_osram_unloader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   rows;
    logic [127:0] O_Q;
    logic [3:0]   O_A;
    logic         O_CEN, O_WEN;
    logic [31:0]  out_data;
    logic         out_valid, out_ready, out_last, busy, done;

    osram_unloader dut (
        .clk(clk), .reset(reset), .start(start), .rows(rows), .O_Q(O_Q),
        .O_A(O_A), .O_CEN(O_CEN), .O_WEN(O_WEN), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [127:0] mem [16];
    always @(posedge clk) if (!O_CEN) O_Q <= mem[O_A];

    int n_cmp = 0, n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    bit          last_q [$];
    int          hs_cyc [$];
    int          rd_q [$];
    int cyc = 0, done_cnt, reads_cnt, beats_cnt, occ_viol, stab_viol, valid_cnt, busy_cnt;
    int val_lat, cen_lat, done_lat;
    bit prev_rst = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    // Stream/read monitor: records handshakes, reads, and protocol violations
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            if (!O_CEN) begin rd_q.push_back(int'(O_A)); reads_cnt++; end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data); last_q.push_back(out_last);
                hs_cyc.push_back(cyc); beats_cnt++;
            end
            if (done) done_cnt++;
            if (out_valid) valid_cnt++;
            if (busy) busy_cnt++;
            if (reads_cnt - beats_cnt / 4 > 2) occ_viol++;
            if (prev_rst && prev_valid && !prev_hs &&
                (!out_valid || out_data !== prev_data || out_last !== prev_last)) stab_viol++;
        end
        prev_rst = reset; prev_valid = out_valid; prev_hs = out_valid && out_ready;
        prev_data = out_data; prev_last = out_last;
    end

    task automatic clear_mon();
        got_q.delete(); last_q.delete(); hs_cyc.delete(); rd_q.delete();
        done_cnt = 0; reads_cnt = 0; beats_cnt = 0; occ_viol = 0; stab_viol = 0;
        valid_cnt = 0; busy_cnt = 0;
    endtask

    // Row r, column c psum = {r, c, random byte}
    task automatic fill_mem();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++)
                mem[r][16*c +: 16] = {4'(r), 4'(c), 8'($urandom)};
    endtask

    // Reference model: rows 0..min(n,16)-1, each split LSB-first into 4 beats
    task automatic build_exp(input int n);
        logic [127:0] row;
        int nr;
        nr = (n > 16) ? 16 : n;
        exp_q.delete();
        for (int r = 0; r < nr; r++) begin
            row = mem[r];
            for (int b = 0; b < 4; b++) exp_q.push_back(row[32*b +: 32]);
        end
    endtask

    // mode 0: ready=1, 1: random ready, 2: ready low for 10 cycles then high
    task automatic run_unload(input int n, input int mode, input bit restart, output bit finished);
        @(posedge clk); #1;
        start = 1'b1; rows = 5'(n); out_ready = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        finished = 1'b0; val_lat = -1; cen_lat = -1; done_lat = -1;
        for (int i = 0; i < 3000 && !finished; i++) begin
            if (mode == 1) out_ready = 1'($urandom % 2);
            else if (mode == 2) out_ready = (i >= 10);
            if (restart && (i % 7 == 3)) begin start = 1'b1; rows = 5'd1; end
            else start = 1'b0;
            @(negedge clk);
            if (val_lat < 0 && out_valid) val_lat = i;
            if (cen_lat < 0 && !O_CEN) cen_lat = i;
            if (done) begin finished = 1'b1; done_lat = i; end
            @(posedge clk); #1;
        end
        start = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; rows = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (O_CEN !== 1'b1) begin n_err++; $display("FAIL rst_cen: got %b expected 1", O_CEN); end
        n_cmp++; if (O_A !== 4'd0) begin n_err++; $display("FAIL rst_addr: got %0d expected 0", O_A); end
        n_cmp++; if (O_WEN !== 1'b1) begin n_err++; $display("FAIL rst_wen: got %b expected 1", O_WEN); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h expected 0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b expected 0", out_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
        @(posedge clk); #1; reset = 1'b1;
    endtask

    task automatic test_full16();
        bit fin; int nl;
        fill_mem(); build_exp(16); clear_mon();
        run_unload(16, 0, 1'b0, fin);
        n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL full16_done_seen: got %b expected 1", fin); end
        n_cmp++; if (got_q.size() !== 64) begin n_err++; $display("FAIL full16_beats: got %0d expected 64", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full16_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        nl = 0; foreach (last_q[i]) nl += int'(last_q[i]);
        n_cmp++; if (nl !== 1) begin n_err++; $display("FAIL full16_last_count: got %0d expected 1", nl); end
        if (last_q.size() == 64) begin
            n_cmp++; if (last_q[63] !== 1'b1) begin n_err++; $display("FAIL full16_last_pos: got %b expected 1", last_q[63]); end
            n_cmp++; if (hs_cyc[63] - hs_cyc[0] !== 63) begin n_err++; $display("FAIL full16_b2b: got span %0d expected 63", hs_cyc[63] - hs_cyc[0]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL full16_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (rd_q.size() !== 16) begin n_err++; $display("FAIL full16_reads: got %0d expected 16", rd_q.size()); end
        for (int i = 0; i < rd_q.size() && i < 16; i++) begin
            n_cmp++; if (rd_q[i] !== i) begin n_err++; $display("FAIL full16_addr%0d: got %0d expected %0d", i, rd_q[i], i); end
        end
        n_cmp++; if (occ_viol !== 0) begin n_err++; $display("FAIL full16_occupancy: got %0d expected 0", occ_viol); end
    endtask

    task automatic test_stall();
        bit fin;
        fill_mem(); build_exp(1); clear_mon();
        run_unload(1, 2, 1'b0, fin);
        n_cmp++; if (cen_lat !== 0) begin n_err++; $display("FAIL stall_cen_lat: got %0d expected 0", cen_lat); end
        n_cmp++; if (val_lat !== 2) begin n_err++; $display("FAIL stall_valid_lat: got %0d expected 2", val_lat); end
        n_cmp++; if (stab_viol !== 0) begin n_err++; $display("FAIL stall_stable: got %0d expected 0", stab_viol); end
        n_cmp++; if (got_q.size() !== 4) begin n_err++; $display("FAIL stall_beats: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (rd_q.size() !== 1) begin n_err++; $display("FAIL stall_reads: got %0d expected 1", rd_q.size()); end
        if (rd_q.size() > 0) begin
            n_cmp++; if (rd_q[0] !== 0) begin n_err++; $display("FAIL stall_addr: got %0d expected 0", rd_q[0]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL stall_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_random_ready();
        bit fin;
        fill_mem(); build_exp(3); clear_mon();
        run_unload(3, 1, 1'b0, fin);
        n_cmp++; if (got_q.size() !== 12) begin n_err++; $display("FAIL rand_beats: got %0d expected 12", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
            n_cmp++; if (last_q[i] !== (i == 11)) begin n_err++; $display("FAIL rand_last%0d: got %b expected %b", i, last_q[i], (i == 11)); end
        end
        n_cmp++; if (occ_viol !== 0) begin n_err++; $display("FAIL rand_occupancy: got %0d expected 0", occ_viol); end
        n_cmp++; if (stab_viol !== 0) begin n_err++; $display("FAIL rand_stable: got %0d expected 0", stab_viol); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rand_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_rows0();
        bit fin;
        clear_mon();
        run_unload(0, 0, 1'b0, fin);
        n_cmp++; if (done_lat !== 0) begin n_err++; $display("FAIL rows0_done_lat: got %0d expected 0", done_lat); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rows0_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (reads_cnt !== 0) begin n_err++; $display("FAIL rows0_reads: got %0d expected 0", reads_cnt); end
        n_cmp++; if (valid_cnt !== 0) begin n_err++; $display("FAIL rows0_valid: got %0d expected 0", valid_cnt); end
        n_cmp++; if (busy_cnt !== 0) begin n_err++; $display("FAIL rows0_busy: got %0d expected 0", busy_cnt); end
    endtask

    task automatic test_clamp();
        bit fin;
        fill_mem(); build_exp(20); clear_mon();
        run_unload(20, 0, 1'b0, fin);
        n_cmp++; if (got_q.size() !== 64) begin n_err++; $display("FAIL clamp_beats: got %0d expected 64", got_q.size()); end
        n_cmp++; if (reads_cnt !== 16) begin n_err++; $display("FAIL clamp_reads: got %0d expected 16", reads_cnt); end
        if (got_q.size() == 64) begin
            n_cmp++; if (got_q[63] !== exp_q[63]) begin n_err++; $display("FAIL clamp_final: got %h expected %h", got_q[63], exp_q[63]); end
            n_cmp++; if (last_q[63] !== 1'b1) begin n_err++; $display("FAIL clamp_last: got %b expected 1", last_q[63]); end
        end
    endtask

    task automatic test_reset_mid();
        bit fin; bit hit;
        fill_mem(); clear_mon();
        @(posedge clk); #1;
        start = 1'b1; rows = 5'd16; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (beats_cnt >= 22) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL rmid_reach_row5: got %0d beats expected 22", beats_cnt); end
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (O_CEN !== 1'b1) begin n_err++; $display("FAIL rmid_cen: got %b expected 1", O_CEN); end
        n_cmp++; if (O_A !== 4'd0) begin n_err++; $display("FAIL rmid_addr: got %0d expected 0", O_A); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rmid_data: got %h expected 0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rmid_last: got %b expected 0", out_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b expected 0", done); end
        @(posedge clk); #1; reset = 1'b1;
        clear_mon();
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (reads_cnt !== 0) begin n_err++; $display("FAIL rmid_no_reads: got %0d expected 0", reads_cnt); end
        n_cmp++; if (valid_cnt !== 0) begin n_err++; $display("FAIL rmid_no_valid: got %0d expected 0", valid_cnt); end
        fill_mem(); build_exp(2); clear_mon();
        run_unload(2, 0, 1'b0, fin);
        n_cmp++; if (got_q.size() !== 8) begin n_err++; $display("FAIL rmid_beats: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rmid_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rmid_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_busy_restart();
        bit fin;
        fill_mem(); build_exp(4); clear_mon();
        run_unload(4, 1, 1'b1, fin);
        n_cmp++; if (got_q.size() !== 16) begin n_err++; $display("FAIL restart_beats: got %0d expected 16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL restart_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL restart_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (reads_cnt !== 4) begin n_err++; $display("FAIL restart_reads: got %0d expected 4", reads_cnt); end
        n_cmp++; if (busy_cnt < 16) begin n_err++; $display("FAIL restart_busy: got %0d cycles expected >=16", busy_cnt); end
        clear_mon();
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (beats_cnt !== 0) begin n_err++; $display("FAIL restart_idle_beats: got %0d expected 0", beats_cnt); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; rows = '0; out_ready = 1'b0;
        test_reset();
        test_full16();
        test_stall();
        test_random_ready();
        test_rows0();
        test_clamp();
        test_reset_mid();
        test_busy_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
